predecode_bundle: RTL
=====================

Name: predecode_bundle

Overview:
Parametrised, registered successor to the single-instruction predecoder. Each cycle it accepts one fetch bundle of N_LANES 32-bit instructions and classifies every lane's control flow. For direct branches and jumps it computes the target. It truncates the bundle after the first unconditional control-flow lane. Results go into a 2-entry output buffer with valid/ready handshakes on both sides, and the block sits between the fetch aligner and the branch-prediction/decode queue.

Parameters:
N_LANES, 4, instructions per bundle (power of 2, 1..8)
PC_W, 64, PC and target width
LIDX_W, $clog2(N_LANES) (min 1), lane index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  drop all buffered bundles; block any push this cycle
in_valid  in  1  input bundle present
in_ready  out  1  block can accept a bundle this cycle
in_pc  in  PC_W  PC of lane 0; lane i PC = in_pc + 4*i (mod 2^PC_W)
in_mask  in  N_LANES  per-lane instruction valid
in_insn  in  32*N_LANES  lane i at bits [32i+31:32i]
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_pc  out  PC_W  bundle PC
out_mask  out  N_LANES  in_mask after truncation
out_pd  out  4*N_LANES  per-lane class code
out_target  out  PC_W*N_LANES  per-lane direct target (0 for non-direct lanes)
out_first_cf_valid  out  1  some unmasked lane is control flow
out_first_cf_idx  out  LIDX_W  lowest such lane
out_redirect  out  1  first unconditional CF is direct (pd 3 or 5)
out_redirect_pc  out  PC_W  its target, else 0

Behaviour:
- Class codes (insn[6:0] = opcode; rd = [11:7]; rs1 = [19:15]; link = reg 1 or 5):
  - 0: not control flow.
  - 1: opcode 0x63.
  - 3: opcode 0x6f with rd not link; 5: opcode 0x6f with rd link.
  - opcode 0x67 with rd=0: 2 (ret) if rs1 link, else 4.
  - opcode 0x67 with rd≠0: 7 if rd and rs1 are both link; 6 if only rd is link; otherwise 4.
- Targets:
  - pd 1: lane PC + sext({[31],[7],[30:25],[11:8],0}).
  - pd 3/5: lane PC + sext({[31],[19:12],[20],[30:21],0}).
  - All other lanes: 0. Arithmetic is mod 2^PC_W.
- Masked-off lanes (in_mask bit 0) report pd 0 and target 0 and are ignored for the first-CF and truncation logic.
- Truncation:
  - The lowest unmasked lane k with pd in 2..7 is the terminator; out_mask bits above k are cleared.
  - out_redirect = 1 if pd[k] is 3 or 5, and out_redirect_pc = target[k].
  - With no terminator, out_mask = in_mask and out_redirect = 0. Conditional branches (pd 1) never truncate.
- Classification and truncation are combinational on the input; all results are written into the buffer.
- Buffer: 2-entry FIFO with head/tail pointers and a count of 0..2.
  - in_ready = (count < 2); it depends only on registered state, with no combinational path from out_ready.
  - A push occurs when in_valid & in_ready & !flush. A pop occurs when out_valid & out_ready.
  - Simultaneous push and pop at count 1 or 2 leaves count unchanged.
  - Latency: a pushed bundle appears on out_* the next cycle if the FIFO was empty. Throughput is 1 bundle/cycle with a continuously ready consumer.
  - out_* is held stable while out_valid & !out_ready.
- flush: next cycle count = 0 and out_valid = 0; a concurrent push or pop is discarded.
- reset: same as flush, and additionally pointers = 0. All outputs read 0 while count = 0. Reset mid-stream loses buffered bundles with no partial output.
- Pointer wrap: 1-bit head/tail pointers wrap naturally.
- in_pc lane overflow wraps mod 2^PC_W.

Test Plan:
- N_LANES=4, in_pc=0x1000, insns {0x00000013, 0x00000863 (beq +16), 0x008000EF (jal x1,+8), 0x00008067 (ret)}, mask 4'b1111 -> pd {0,1,5,2}, target[1]=0x1014, target[2]=0x1010, out_mask=4'b0111, first_cf_idx=1, redirect=1, redirect_pc=0x1010, out_valid 1 cycle after push.
- Lane 0 = 0xFFDFF06F (j -4), in_pc=0x2000 -> pd[0]=3, target 0x1FFC, out_mask=4'b0001, redirect_pc=0x1FFC. Same bundle with in_mask bit0=0 -> pd[0]=0, no redirect, out_mask = in_mask.
- JALR variants in lane 0 -> x0,x1 gives pd 2; x0,x6 gives 4; x1,x6 gives 6; x5,x1 gives 7; x6,x1 gives 4. For 6/7/4, redirect=0 and mask truncated after lane 0.
- Backpressure: hold out_ready=0, push 3 bundles -> in_ready drops after the 2nd push, the 3rd is accepted only after the first pop, order preserved, out_* stable while stalled.
- flush asserted with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed-cycle bundle is not delivered.
- Assert reset for 1 cycle mid-stream -> all outputs 0 next cycle. in_pc=0xFFFF_FFFF_FFFF_FFFC with lane 1 jal +8 -> target wraps to 0x8.

Source files
------------

// File: rtl/predecode_bundle.sv
// Bundle predecoder: classifies each lane's control flow, computes direct targets,
// truncates after the first unconditional CF lane, and buffers results in a 2-entry FIFO.
module predecode_bundle #(
    parameter int unsigned N_LANES = 4,
    parameter int unsigned PC_W    = 64,
    parameter int unsigned LIDX_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [PC_W-1:0]         in_pc_i,
    input  logic [N_LANES-1:0]      in_mask_i,
    input  logic [32*N_LANES-1:0]   in_insn_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [PC_W-1:0]         out_pc_o,
    output logic [N_LANES-1:0]      out_mask_o,
    output logic [4*N_LANES-1:0]    out_pd_o,
    output logic [PC_W*N_LANES-1:0] out_target_o,
    output logic                    out_first_cf_valid_o,
    output logic [LIDX_W-1:0]       out_first_cf_idx_o,
    output logic                    out_redirect_o,
    output logic [PC_W-1:0]         out_redirect_pc_o
);

    typedef struct packed {
        logic [PC_W-1:0]         pc;
        logic [N_LANES-1:0]      mask;
        logic [4*N_LANES-1:0]    pd;
        logic [PC_W*N_LANES-1:0] target;
        logic                    first_cf_valid;
        logic [LIDX_W-1:0]       first_cf_idx;
        logic                    redirect;
        logic [PC_W-1:0]         redirect_pc;
    } entry_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [3:0] classify(input logic [6:0] opcode, input logic [4:0] rd,
                                            input logic [4:0] rs1);
        logic [3:0] pd;
        pd = 4'd0;
        unique case (opcode)
            7'h63: pd = 4'd1;
            7'h6f: pd = is_link(rd) ? 4'd5 : 4'd3;
            7'h67: begin
                if (rd == 5'd0) begin
                    pd = is_link(rs1) ? 4'd2 : 4'd4;
                end else if (is_link(rd)) begin
                    pd = is_link(rs1) ? 4'd7 : 4'd6;
                end else begin
                    pd = 4'd4;
                end
            end
            default: pd = 4'd0;
        endcase
        return pd;
    endfunction

    // ---------------------------------------------------------------- per-lane decode
    logic [3:0]      lane_pd  [N_LANES];
    logic [PC_W-1:0] lane_tgt [N_LANES];

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic [31:0]     insn;
        logic [PC_W-1:0] lane_pc;
        logic [PC_W-1:0] b_imm;
        logic [PC_W-1:0] j_imm;
        logic [3:0]      pd_raw;

        assign insn    = in_insn_i[32*g +: 32];
        assign lane_pc = in_pc_i + PC_W'(4 * g);
        assign b_imm   = {{(PC_W-12){insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
        assign j_imm   = {{(PC_W-20){insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
        assign pd_raw  = classify(insn[6:0], insn[11:7], insn[19:15]);

        always_comb begin
            lane_pd[g]  = 4'd0;
            lane_tgt[g] = '0;
            if (in_mask_i[g]) begin
                lane_pd[g] = pd_raw;
                if (pd_raw == 4'd1) begin
                    lane_tgt[g] = lane_pc + b_imm;
                end else if ((pd_raw == 4'd3) || (pd_raw == 4'd5)) begin
                    lane_tgt[g] = lane_pc + j_imm;
                end
            end
        end
    end

    // ---------------------------------------------------------------- bundle summary
    entry_t push_entry;

    always_comb begin
        logic keep;
        logic term_found;
        push_entry = '0;
        keep       = 1'b1;
        term_found = 1'b0;
        push_entry.pc = in_pc_i;
        for (int i = 0; i < N_LANES; i++) begin
            push_entry.pd[4*i +: 4]        = lane_pd[i];
            push_entry.target[PC_W*i +: PC_W] = lane_tgt[i];
            push_entry.mask[i]             = in_mask_i[i] & keep;
            if (!push_entry.first_cf_valid && (lane_pd[i] != 4'd0)) begin
                push_entry.first_cf_valid = 1'b1;
                push_entry.first_cf_idx   = LIDX_W'(i);
            end
            // Lanes past the first unconditional CF are never executed.
            if (!term_found && (lane_pd[i] >= 4'd2)) begin
                term_found = 1'b1;
                keep       = 1'b0;
                if ((lane_pd[i] == 4'd3) || (lane_pd[i] == 4'd5)) begin
                    push_entry.redirect    = 1'b1;
                    push_entry.redirect_pc = lane_tgt[i];
                end
            end
        end
    end

    // ---------------------------------------------------------------- 2-entry FIFO
    entry_t     mem_q [2];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            // Realign head to tail so the next push lands at the head slot.
            head_d  = tail_q;
            count_d = 2'd0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            if (push && !pop) count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    entry_t head_entry;
    assign head_entry = out_valid_o ? mem_q[head_q] : '0;

    assign out_pc_o             = head_entry.pc;
    assign out_mask_o           = head_entry.mask;
    assign out_pd_o             = head_entry.pd;
    assign out_target_o         = head_entry.target;
    assign out_first_cf_valid_o = head_entry.first_cf_valid;
    assign out_first_cf_idx_o   = head_entry.first_cf_idx;
    assign out_redirect_o       = head_entry.redirect;
    assign out_redirect_pc_o    = head_entry.redirect_pc;

endmodule
